// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for a Galois LFSR bit stream
// Acquires, verifies and tracks the stream; counts mispredicted bits while locked.
module lfsr_checker #(
  parameter int unsigned Poly          = 32'hD008,
  parameter int unsigned Size          = $clog2(Poly),
  parameter bit          StuckProtect  = 1'b0,
  parameter int unsigned VerifyLen     = 32,
  parameter int unsigned WindowLen     = 256,
  parameter int unsigned LossThreshold = 16,
  parameter int unsigned CountWidth    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic                  data_i,
  input  logic                  resync_i,
  input  logic                  clear_i,
  output logic                  locked_o,
  output logic                  error_o,
  output logic                  lock_lost_o,
  output logic [CountWidth-1:0] err_count_o
);

  localparam int unsigned AcqW  = $clog2(Size + 1);
  localparam int unsigned GoodW = $clog2(VerifyLen + 1);
  localparam int unsigned WinW  = $clog2(WindowLen);
  localparam int unsigned ErrW  = $clog2(LossThreshold + 1);
  localparam logic [Size-1:0] PolyBits = Size'(Poly);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t                r_state;
  logic [Size-1:0]       r_lreg;
  logic [AcqW-1:0]       r_acq_cnt;
  logic [GoodW-1:0]      r_good_cnt;
  logic [WinW-1:0]       r_win_cnt;
  logic [ErrW-1:0]       r_win_err;
  logic                  r_locked;
  logic                  r_error;
  logic                  r_lock_lost;
  logic [CountWidth-1:0] r_err_count;

  logic                  w_pred;
  logic                  w_f;
  logic                  w_mis;
  logic [Size-1:0]       w_lreg_next;
  logic [ErrW-1:0]       w_win_err_inc;

  assign w_pred        = (StuckProtect && (&r_lreg)) ? 1'b0 : r_lreg[0];
  // Only ACQUIRE slaves the register to the line; afterwards errors cannot corrupt it.
  assign w_f           = (r_state == ST_ACQUIRE) ? data_i : w_pred;
  assign w_mis         = data_i ^ w_pred;
  assign w_win_err_inc = r_win_err + ErrW'(w_mis);

  always_comb begin
    w_lreg_next         = r_lreg;
    w_lreg_next[Size-1] = w_f;
    for (int i = 1; i < Size; i++) begin
      w_lreg_next[i-1] = PolyBits[i-1] ? ~(r_lreg[i] ^ w_f) : r_lreg[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_ACQUIRE;
      r_lreg      <= '0;
      r_acq_cnt   <= '0;
      r_good_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_error     <= 1'b0;
      r_lock_lost <= 1'b0;
      if (resync_i) begin
        r_state   <= ST_ACQUIRE;
        r_acq_cnt <= '0;
        r_locked  <= 1'b0;
      end else if (valid_i) begin
        r_lreg <= w_lreg_next;
        case (r_state)
          ST_ACQUIRE: begin
            if (r_acq_cnt == AcqW'(Size - 1)) begin
              r_state    <= ST_VERIFY;
              r_acq_cnt  <= '0;
              r_good_cnt <= '0;
            end else begin
              r_acq_cnt <= r_acq_cnt + AcqW'(1);
            end
          end
          ST_VERIFY: begin
            if (w_mis) begin
              r_state   <= ST_ACQUIRE;
              r_acq_cnt <= '0;
            end else if (r_good_cnt == GoodW'(VerifyLen - 1)) begin
              r_state   <= ST_LOCKED;
              r_locked  <= 1'b1;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GoodW'(1);
            end
          end
          ST_LOCKED: begin
            if (w_mis) begin
              r_error <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + CountWidth'(1);
            end
            // Threshold test uses the updated error total, so the window-closing bit still counts.
            if (w_mis && (w_win_err_inc == ErrW'(LossThreshold))) begin
              r_state     <= ST_ACQUIRE;
              r_acq_cnt   <= '0;
              r_locked    <= 1'b0;
              r_lock_lost <= 1'b1;
            end else if (r_win_cnt == WinW'(WindowLen - 1)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WinW'(1);
              r_win_err <= w_win_err_inc;
            end
          end
          default: r_state <= ST_ACQUIRE;
        endcase
      end
      if (clear_i) r_err_count <= '0;
    end
  end

  assign locked_o    = r_locked;
  assign error_o     = r_error;
  assign lock_lost_o = r_lock_lost;
  assign err_count_o = r_err_count;

endmodule
